arb_order_resp_router: RTL and testbench
========================================

# arb_order_resp_router

Return-path partner of the interleaved weighted round-robin arbiter. It records the order in which the arbiter issues grants and steers the shared response stream (B-style single beat or R-style burst ending in `last`) back to the granted requester in that same order. It sits between a shared in-order target port and the N requester response ports of the interconnect.

## Interface
Parameters:
- `P_REQUESTER_NUM`, 4: number of requesters; must be ≥2.
- `P_ORDER_DEPTH`, 8: maximum outstanding grants; must be a power of two and ≥2.
- `P_DATA_W`, 32: response payload width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `grant_valid_i`  in  P_REQUESTER_NUM  one-hot grant from the arbiter.
- `grant_ready_o`  out  1  order FIFO can accept a grant.
- `rsp_valid_i`  in  1  shared response valid.
- `rsp_ready_o`  out  1  shared response ready.
- `rsp_last_i`  in  1  final beat of the current response.
- `rsp_data_i`  in  P_DATA_W  response payload.
- `rsp_valid_o`  out  P_REQUESTER_NUM  per-requester response valid; at most one bit set.
- `rsp_ready_i`  in  P_REQUESTER_NUM  per-requester response ready.
- `rsp_data_o`  out  P_DATA_W  payload broadcast to all requesters.
- `rsp_last_o`  out  1  `last` broadcast to all requesters.
- `order_cnt_o`  out  $clog2(P_ORDER_DEPTH)+1  number of outstanding grants.

## Operation
- **Push.** A grant is pushed when `|grant_valid_i && grant_ready_o`.
  - `grant_ready_o = ~full`.
  - The grant is encoded to an index of width `REQ_NUM_W = $clog2(P_REQUESTER_NUM)` and written at the write pointer.
  - A multi-hot grant is illegal. If one occurs, the lowest set bit is stored.
- **Head.** The entry at the read pointer is the current destination `head_idx`.
- **Routing when the FIFO is not empty:**
  - `rsp_valid_o[head_idx] = rsp_valid_i`; all other bits are 0.
  - `rsp_ready_o = rsp_ready_i[head_idx]`.
- **Routing when the FIFO is empty:** `rsp_ready_o = 0` and `rsp_valid_o = 0`. Responses with no matching grant are stalled, never dropped.
- `rsp_data_o` and `rsp_last_o` are always direct copies of `rsp_data_i` and `rsp_last_i`.
- **Beats and pop.**
  - A beat transfers when `rsp_valid_i && rsp_ready_o`.
  - A non-last beat leaves the FIFO unchanged.
  - A transferred beat with `rsp_last_i = 1` pops the head.
- **Pointers.** Read and write pointers are `$clog2(P_ORDER_DEPTH)+1` bits wide, using an extra wrap bit.
  - `full` when the MSBs differ and the remaining bits are equal.
  - `empty` when the pointers are equal.
  - `order_cnt_o = wptr - rptr`, modulo 2^width.
- **Simultaneous push and pop:**
  - Both occur in the same cycle; the count is unchanged.
  - When full, the push is refused because `grant_ready_o = 0` that cycle. There is no pop-bypass.
  - When empty, there is no bypass: a grant pushed in cycle t can be served no earlier than cycle t+1.
- **Reset.** Asserting `rst_n` low at any time immediately (asynchronously) clears the pointers. Outstanding grants are discarded.

## Timing
- Reset values:
  - `grant_ready_o = 1`
  - `rsp_ready_o = 0`
  - `rsp_valid_o = 0`
  - `order_cnt_o = 0`
  - `rsp_data_o` and `rsp_last_o` follow their inputs.
- Latency:
  - Grant to routable: 1 cycle.
  - Response path: 0 cycles (combinational valid, ready, data and last).
  - Pop effect on the next head: the following cycle.
- Back-to-back single-beat responses to different requesters sustain 1 beat/cycle.
- `grant_ready_o` depends only on state and never combinationally on `grant_valid_i`.
- Only the `rsp_valid_i`/`rsp_ready_i` to `rsp_valid_o`/`rsp_ready_o` path is combinational.

## Structure
- No shared package is needed. `REQ_NUM_W` and the pointer width are localparams.
- Sub-module `arb_order_fifo` is a parameterised synchronous FIFO:
  - Width `REQ_NUM_W`, depth `P_ORDER_DEPTH`.
  - Async active-low reset.
  - Ports: push, pop, full, empty, count, head.
- The top level holds the one-hot-to-index encoder and the steering logic.

## Test plan
- **Reset and single grant.** Hold `rst_n` low for 3 cycles, then push grant `4'b0100`. Next cycle, send one beat with `last=1` and `rsp_ready_i = 4'b1111`. Required: beat appears on `rsp_valid_o = 4'b0100`; `order_cnt_o` goes 0→1→0.
- **Ordering.** Push grants 0, 3, 1, with 2-beat, 1-beat and 3-beat bursts respectively. Required: beats are routed to 0,0,3,1,1,1 in that order; a pop occurs only on the `last` beats.
- **Full and simultaneous push/pop.** Push 8 grants; `grant_ready_o` drops to 0 after the 8th. Then present a 9th grant in the same cycle as a `last` beat. Required: the grant is refused that cycle, `order_cnt_o` becomes 7, and it is accepted the next cycle, restoring the count to 8. Also cover pointer wrap after 16 push/pop pairs.
- **Empty and backpressure.**
  - `rsp_valid_i = 1` with no grant outstanding: `rsp_ready_o = 0` and `rsp_valid_o = 0` for 5 cycles.
  - With a grant to requester 2 and `rsp_ready_i[2] = 0`: the beat is held, other requesters' ready bits are ignored, and the beat transfers when `rsp_ready_i[2]` rises.
- **Reset mid-burst.** Assert `rst_n` low after beat 1 of a 4-beat burst with 3 grants queued. Required: outputs go to their reset values asynchronously, before the next `clk` edge, and `order_cnt_o = 0`.
- **Multi-hot grant.** Push `4'b1010`. Required: routed to requester 1.

Source files
------------

// File: rtl/arb_order_fifo.sv
// arb_order_fifo: grant-order FIFO with wrap-bit pointers and async active-low reset
module arb_order_fifo #(
  parameter int P_WIDTH = 2,
  parameter int P_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [P_WIDTH-1:0]         data_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(P_DEPTH):0]   count_o,
  output logic [P_WIDTH-1:0]         head_o
);
  localparam int AW = $clog2(P_DEPTH);
  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic do_push, do_pop;
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = wptr_q == rptr_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign wptr_d  = wptr_q + (AW+1)'(do_push);
  assign rptr_d  = rptr_q + (AW+1)'(do_pop);
  assign count_o = wptr_q - rptr_q;
  assign head_o  = mem_q[rptr_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  // storage is not reset: an entry is only read after it has been written
  always_ff @(posedge clk)
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/arb_order_resp_router.sv
// arb_order_resp_router: steers the shared in-order response stream back to requesters in grant order
module arb_order_resp_router #(
  parameter int P_REQUESTER_NUM = 4,
  parameter int P_ORDER_DEPTH   = 8,
  parameter int P_DATA_W        = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [P_REQUESTER_NUM-1:0]       grant_valid_i,
  output logic                             grant_ready_o,
  input  logic                             rsp_valid_i,
  output logic                             rsp_ready_o,
  input  logic                             rsp_last_i,
  input  logic [P_DATA_W-1:0]              rsp_data_i,
  output logic [P_REQUESTER_NUM-1:0]       rsp_valid_o,
  input  logic [P_REQUESTER_NUM-1:0]       rsp_ready_i,
  output logic [P_DATA_W-1:0]              rsp_data_o,
  output logic                             rsp_last_o,
  output logic [$clog2(P_ORDER_DEPTH):0]   order_cnt_o
);
  localparam int REQ_NUM_W = $clog2(P_REQUESTER_NUM);
  localparam int PTR_W     = $clog2(P_ORDER_DEPTH) + 1;
  logic [REQ_NUM_W-1:0] grant_idx, head_idx;
  logic [PTR_W-1:0] cnt;
  logic full, empty, push, pop;
  // descending scan so a multi-hot grant resolves to its lowest set bit
  always_comb begin
    grant_idx = '0;
    for (int i = P_REQUESTER_NUM - 1; i >= 0; i--)
      if (grant_valid_i[i]) grant_idx = REQ_NUM_W'(i);
  end
  assign grant_ready_o = ~full;
  assign push          = |grant_valid_i & grant_ready_o;
  assign rsp_ready_o   = ~empty & rsp_ready_i[head_idx];
  assign rsp_valid_o   = (rsp_valid_i & ~empty) ? P_REQUESTER_NUM'(1) << head_idx : '0;
  assign pop           = rsp_valid_i & rsp_ready_o & rsp_last_i;
  assign rsp_data_o    = rsp_data_i;
  assign rsp_last_o    = rsp_last_i;
  assign order_cnt_o   = cnt;
  arb_order_fifo #(
    .P_WIDTH (REQ_NUM_W),
    .P_DEPTH (P_ORDER_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (grant_idx),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cnt),
    .head_o  (head_idx)
  );
endmodule

// File: tb/tb_arb_order_resp_router.sv
// tb_arb_order_resp_router: scoreboard bench for the grant-order response router
module tb_arb_order_resp_router;
  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
    logic        last;
  } exp_t;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [3:0]  grant_valid_i = '0;
  logic        grant_ready_o;
  logic        rsp_valid_i = 0;
  logic        rsp_ready_o;
  logic        rsp_last_i = 0;
  logic [31:0] rsp_data_i = '0;
  logic [3:0]  rsp_valid_o;
  logic [3:0]  rsp_ready_i = 4'b1111;
  logic [31:0] rsp_data_o;
  logic        rsp_last_o;
  logic [3:0]  order_cnt_o;
  int n_chk = 0;
  int n_err = 0;
  exp_t sb[$];
  exp_t mon_e;
  arb_order_resp_router #(
    .P_REQUESTER_NUM (4),
    .P_ORDER_DEPTH   (8),
    .P_DATA_W        (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .grant_valid_i (grant_valid_i),
    .grant_ready_o (grant_ready_o),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_ready_o   (rsp_ready_o),
    .rsp_last_i    (rsp_last_i),
    .rsp_data_i    (rsp_data_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_data_o    (rsp_data_o),
    .rsp_last_o    (rsp_last_o),
    .order_cnt_o   (order_cnt_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // every transferred beat must match the oldest expected beat
  always @(negedge clk)
    if (rst_n && rsp_valid_i && rsp_ready_o) begin
      if (sb.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("route", rsp_valid_o, mon_e.mask);
        chk("data", rsp_data_o, mon_e.data);
        chk("last", rsp_last_o, mon_e.last);
      end
    end
  task automatic push_grant(input logic [3:0] g);
    grant_valid_i = g;
    chk("grant_ready", grant_ready_o, 1);
    tick();
    grant_valid_i = '0;
  endtask
  task automatic send_beat(input int dest, input logic [31:0] d, input logic l);
    bit ok = 0;
    rsp_valid_i = 1;
    rsp_data_i  = d;
    rsp_last_i  = l;
    sb.push_back('{4'b0001 << dest, d, l});
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (rsp_ready_o) ok = 1;
      tick();
    end
    if (!ok) chk("beat_timeout", 0, 1);
    rsp_valid_i = 0;
  endtask
  initial begin
    // reset values, with response inputs active to show pass-through
    rsp_valid_i = 1;
    rsp_last_i  = 1;
    rsp_data_i  = 32'hA5A5_0001;
    repeat (3) tick();
    chk("rst_grant_ready", grant_ready_o, 1);
    chk("rst_rsp_ready", rsp_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_cnt", order_cnt_o, 0);
    chk("rst_data_thru", rsp_data_o, 32'hA5A5_0001);
    chk("rst_last_thru", rsp_last_o, 1);
    rsp_valid_i = 0;
    rst_n = 1;
    tick();
    // single grant; response presented in the push cycle must not bypass
    grant_valid_i = 4'b0100;
    rsp_valid_i   = 1;
    rsp_last_i    = 1;
    rsp_data_i    = 32'h1111_0001;
    #1;
    chk("nobypass_ready", rsp_ready_o, 0);
    chk("nobypass_valid", rsp_valid_o, 0);
    tick();
    grant_valid_i = '0;
    sb.push_back('{4'b0100, 32'h1111_0001, 1'b1});
    chk("single_cnt1", order_cnt_o, 1);
    chk("single_ready", rsp_ready_o, 1);
    tick();
    rsp_valid_i = 0;
    chk("single_cnt0", order_cnt_o, 0);
    // ordering with bursts
    push_grant(4'b0001);
    push_grant(4'b1000);
    push_grant(4'b0010);
    chk("ord_cnt3", order_cnt_o, 3);
    send_beat(0, 32'h2000_0000, 0);
    chk("ord_nonlast_keep", order_cnt_o, 3);
    send_beat(0, 32'h2000_0001, 1);
    chk("ord_pop1", order_cnt_o, 2);
    send_beat(3, 32'h2000_0002, 1);
    chk("ord_pop2", order_cnt_o, 1);
    send_beat(1, 32'h2000_0003, 0);
    send_beat(1, 32'h2000_0004, 0);
    chk("ord_nonlast_keep2", order_cnt_o, 1);
    send_beat(1, 32'h2000_0005, 1);
    chk("ord_empty", order_cnt_o, 0);
    // fill to full
    for (int i = 0; i < 8; i++) push_grant(4'b0001 << (i % 4));
    chk("full_cnt", order_cnt_o, 8);
    chk("full_grant_ready", grant_ready_o, 0);
    // grant coinciding with a popping beat while full is refused
    grant_valid_i = 4'b0001;
    rsp_valid_i   = 1;
    rsp_last_i    = 1;
    rsp_data_i    = 32'h3000_0000;
    sb.push_back('{4'b0001, 32'h3000_0000, 1'b1});
    #1;
    chk("full_refuse_ready", grant_ready_o, 0);
    chk("full_pop_ready", rsp_ready_o, 1);
    tick();
    rsp_valid_i = 0;
    chk("full_cnt7", order_cnt_o, 7);
    chk("full_regrant_ready", grant_ready_o, 1);
    tick();
    grant_valid_i = '0;
    chk("full_cnt8", order_cnt_o, 8);
    for (int i = 1; i < 8; i++) send_beat(i % 4, 32'h3000_0000 + i, 1);
    send_beat(0, 32'h3000_0008, 1);
    chk("drain_cnt", order_cnt_o, 0);
    // pointer wrap
    for (int i = 0; i < 16; i++) begin
      push_grant(4'b0001 << ((i + 1) % 4));
      send_beat((i + 1) % 4, 32'h4000_0000 + i, 1);
    end
    chk("wrap_cnt", order_cnt_o, 0);
    // empty: response stalls
    rsp_valid_i = 1;
    rsp_last_i  = 1;
    rsp_data_i  = 32'h5000_0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("empty_ready", rsp_ready_o, 0);
      chk("empty_valid", rsp_valid_o, 0);
      tick();
    end
    rsp_valid_i = 0;
    // backpressure from requester 2 only
    push_grant(4'b0100);
    rsp_ready_i = 4'b1011;
    rsp_valid_i = 1;
    rsp_data_i  = 32'h6000_0000;
    sb.push_back('{4'b0100, 32'h6000_0000, 1'b1});
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", rsp_ready_o, 0);
      chk("bp_valid", rsp_valid_o, 4'b0100);
      tick();
    end
    chk("bp_cnt_held", order_cnt_o, 1);
    rsp_ready_i = 4'b0100;
    #1;
    chk("bp_release", rsp_ready_o, 1);
    tick();
    rsp_valid_i = 0;
    rsp_ready_i = 4'b1111;
    chk("bp_cnt0", order_cnt_o, 0);
    // asynchronous reset mid-burst
    push_grant(4'b0100);
    push_grant(4'b0010);
    push_grant(4'b1000);
    send_beat(2, 32'h7000_0000, 0);
    rsp_valid_i = 1;
    rsp_last_i  = 0;
    rsp_data_i  = 32'h7000_0001;
    #1;
    chk("pre_rst_valid", rsp_valid_o, 4'b0100);
    #1;
    rst_n = 0;
    #1;
    chk("arst_cnt", order_cnt_o, 0);
    chk("arst_grant_ready", grant_ready_o, 1);
    chk("arst_rsp_ready", rsp_ready_o, 0);
    chk("arst_rsp_valid", rsp_valid_o, 0);
    rsp_valid_i = 0;
    tick();
    rst_n = 1;
    tick();
    chk("post_rst_cnt", order_cnt_o, 0);
    // multi-hot grant resolves to lowest bit
    push_grant(4'b1010);
    send_beat(1, 32'h8000_0000, 1);
    chk("multihot_cnt", order_cnt_o, 0);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
